// File: rtl/regfile_pkg.sv
// Shared types and default sizes for the pipelined register file.
// Holds the clear-sequencer state encoding.
package regfile_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_NRD   = 2;

endpackage

// File: rtl/regfile_clr_seq.sv
// Post-reset clear sequencer: walks index 1..NREGS-1, then runs.
// Never wraps; only reset brings it back to CLEAR.
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = DEF_NREGS
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     ready,
  output logic [$clog2(NREGS)-1:0] clr_idx
);

  localparam int AW = $clog2(NREGS);
  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  state_t        state;
  state_t        state_nx;
  logic [AW-1:0] idx;
  logic [AW-1:0] idx_nx;

  // state and index registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= CLEAR;
      idx   <= AW'(1);
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // advance the index, leave CLEAR after the last register
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (state)
      CLEAR: begin
        if (idx == LAST) state_nx = RUN;
        else idx_nx = idx + 1'b1;
      end
      RUN: ;
      default: state_nx = CLEAR;
    endcase
  end

  assign ready   = (state == RUN);
  assign clr_idx = idx;

endmodule

// File: rtl/regfile_pipe.sv
// Register file with per-register pending bits and a clear sequence.
// Optional write-to-read bypass: define REGFILE_PIPE_BYPASS_EN.
module regfile_pipe
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int NRD   = DEF_NRD
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [NRD-1:0][$clog2(NREGS)-1:0]  ra,
  output logic [NRD-1:0][WIDTH-1:0]          rd,
  output logic [NRD-1:0]                     rpend,
  input  logic                               we3,
  input  logic [$clog2(NREGS)-1:0]           a3,
  input  logic [WIDTH-1:0]                   wd3,
  input  logic                               pset,
  input  logic [$clog2(NREGS)-1:0]           pidx,
  output logic                               ready
);

  localparam int AW = $clog2(NREGS);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] pend;
  logic [AW-1:0]    clr_idx;
  logic             wr_ok;
  logic             ps_ok;

  regfile_clr_seq #(
    .NREGS(NREGS)
  ) u_seq (
    .clk    (clk),
    .reset  (reset),
    .ready  (ready),
    .clr_idx(clr_idx)
  );

  assign wr_ok = ready && we3 && (a3 != '0);
  assign ps_ok = ready && pset && (pidx != '0);

  // clear walk, then writes; a same-index pset wins over the write's clear
  always_ff @(posedge clk) begin
    if (!ready) begin
      regs[clr_idx] <= '0;
      pend[clr_idx] <= 1'b0;
    end else begin
      if (wr_ok) begin
        regs[a3] <= wd3;
        pend[a3] <= 1'b0;
      end
      if (ps_ok) pend[pidx] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]    a;
    logic             hit;
    logic [WIDTH-1:0] dv;
    logic             pv;

    assign a = ra[i];
`ifdef REGFILE_PIPE_BYPASS_EN
    assign hit = wr_ok && (a3 == a);
`else
    assign hit = 1'b0;
`endif

    // read mux: zero while clearing and for register 0
    always_comb begin
      dv = '0;
      pv = 1'b0;
      if (ready && (a != '0)) begin
        dv = hit ? wd3 : regs[a];
        pv = hit ? (ps_ok && (pidx == a)) : pend[a];
      end
    end

    assign rd[i]    = dv;
    assign rpend[i] = pv;
  end

endmodule

// File: tb/tb_regfile_pipe.sv
// Directed self-checking bench for regfile_pipe (NREGS=32, NRD=2).
// Expectations follow REGFILE_PIPE_BYPASS_EN when it is defined.
module tb_regfile_pipe;

`ifdef REGFILE_PIPE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0][4:0]  ra;
  logic [1:0][31:0] rd;
  logic [1:0]       rpend;
  logic             we3;
  logic [4:0]       a3;
  logic [31:0]      wd3;
  logic             pset;
  logic [4:0]       pidx;
  logic             ready;

  int npass = 0;
  int ntot  = 0;
  int ncyc;

  regfile_pipe dut (
    .clk  (clk),
    .reset(reset),
    .ra   (ra),
    .rd   (rd),
    .rpend(rpend),
    .we3  (we3),
    .a3   (a3),
    .wd3  (wd3),
    .pset (pset),
    .pidx (pidx),
    .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (n < 60) begin
      tick();
      n++;
      if (ready) break;
    end
  endtask

  task automatic idle();
    we3  = 1'b0;
    a3   = '0;
    wd3  = '0;
    pset = 1'b0;
    pidx = '0;
  endtask

  initial begin
    reset = 1'b0;
    ra    = '0;
    idle();
    repeat (3) tick();
    chk("rst_ready", {31'b0, ready}, 32'd0);
    chk("rst_rd0", rd[0], 32'd0);
    chk("rst_rpend", {30'b0, rpend}, 32'd0);

    // writes and pset during CLEAR must be ignored
    we3  = 1'b1;
    a3   = 5'd9;
    wd3  = 32'h55;
    pset = 1'b1;
    pidx = 5'd9;
    ra[0] = 5'd9;
    #2;
    reset = 1'b1;
    #1;
    chk("clr_rd9", rd[0], 32'd0);
    chk("clr_pend9", {31'b0, rpend[0]}, 32'd0);
    wait_ready(ncyc);
    chk("clr_cycles", ncyc, 32'd31);
    chk("clr_ready", {31'b0, ready}, 32'd1);
    idle();
    #1;
    chk("reg9_after_clr", rd[0], 32'd0);
    chk("pend9_after_clr", {31'b0, rpend[0]}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      ra[1] = 5'(i);
      #1;
      chk($sformatf("zero_r%0d", i), rd[1], 32'd0);
    end

    // write reg 5 with same-cycle read
    we3   = 1'b1;
    a3    = 5'd5;
    wd3   = 32'hDEAD_BEEF;
    ra[0] = 5'd5;
    #1;
    chk("wr5_same", rd[0], BYP ? 32'hDEAD_BEEF : 32'd0);
    chk("wr5_same_pend", {31'b0, rpend[0]}, 32'd0);
    tick();
    idle();
    #1;
    chk("wr5_next", rd[0], 32'hDEAD_BEEF);

    // pending bit on reg 7
    pset = 1'b1;
    pidx = 5'd7;
    tick();
    idle();
    ra[1] = 5'd7;
    #1;
    chk("p7_set", {31'b0, rpend[1]}, 32'd1);
    we3 = 1'b1;
    a3  = 5'd7;
    wd3 = 32'h77;
    #1;
    chk("p7_wr_same", {31'b0, rpend[1]}, BYP ? 32'd0 : 32'd1);
    tick();
    idle();
    #1;
    chk("p7_cleared", {31'b0, rpend[1]}, 32'd0);
    chk("r7_data", rd[1], 32'h77);
    we3  = 1'b1;
    a3   = 5'd7;
    wd3  = 32'h78;
    pset = 1'b1;
    pidx = 5'd7;
    #1;
    chk("p7_both_same_rd", rd[1], BYP ? 32'h78 : 32'h77);
    chk("p7_both_same_p", {31'b0, rpend[1]}, BYP ? 32'd1 : 32'd0);
    tick();
    idle();
    ra[0] = 5'd7;
    #1;
    chk("p7_both_rd", rd[1], 32'h78);
    chk("p7_both_p", {31'b0, rpend[1]}, 32'd1);
    chk("port0_same_reg", rd[0], 32'h78);
    chk("port0_same_p", {31'b0, rpend[0]}, 32'd1);

    // register 0 is hardwired
    we3  = 1'b1;
    a3   = 5'd0;
    wd3  = 32'h1234;
    pset = 1'b1;
    pidx = 5'd0;
    ra[0] = 5'd0;
    #1;
    chk("r0_same", rd[0], 32'd0);
    tick();
    idle();
    #1;
    chk("r0_rd", rd[0], 32'd0);
    chk("r0_pend", {31'b0, rpend[0]}, 32'd0);
    ra[0] = 5'd5;
    #1;
    chk("r5_kept", rd[0], 32'hDEAD_BEEF);

    // reset mid-run
    we3 = 1'b1;
    a3  = 5'd3;
    wd3 = 32'hAAAA;
    tick();
    idle();
    ra[0] = 5'd3;
    #1;
    chk("r3_written", rd[0], 32'hAAAA);
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", {31'b0, ready}, 32'd0);
    chk("mid_rst_rd", rd[0], 32'd0);
    chk("mid_rst_rpend", {31'b0, rpend[1]}, 32'd0);
    tick();
    #2;
    reset = 1'b1;
    wait_ready(ncyc);
    chk("reclr_cycles", ncyc, 32'd31);
    #1;
    chk("reclr_r3", rd[0], 32'd0);
    chk("reclr_p7", {31'b0, rpend[1]}, 32'd0);
    chk("reclr_r7", rd[1], 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
